// File: rtl/bp_fe_bp_gshare_bht_pkg.sv
// Shared counter helpers for the gshare BHT: init value and saturation limits.
// Optional macro BP_GSHARE_WR_BYPASS_EN is consumed by the top, not here.
package bp_fe_bp_gshare_pkg;

    localparam int unsigned cnt_sat_bits_lp   = 2;
    localparam int unsigned cnt_taken_msb_lp  = cnt_sat_bits_lp - 1;
    localparam int unsigned cnt_sat_max_lp    = (1 << cnt_sat_bits_lp) - 1;
    localparam int unsigned cnt_sat_min_lp    = 0;

    // Weakly-not-taken: MSB clear, all lower bits set.
    function automatic int unsigned cnt_init(input int unsigned w);
        return (32'd1 << (w - 32'd1)) - 32'd1;
    endfunction

    function automatic int unsigned cnt_max(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/bp_fe_bp_gshare_bht_if.sv
// Read/predict and update ports of the gshare BHT, bundled for the top-level port list.
interface bp_fe_bp_gshare_bht_if #(
    parameter int bht_idx_width_p = 9
);
    logic                       w_v_i;
    logic [bht_idx_width_p-1:0] idx_w_i;
    logic                       correct_i;
    logic                       r_v_i;
    logic [bht_idx_width_p-1:0] idx_r_i;
    logic                       predict_o;

    modport master (
        output w_v_i, idx_w_i, correct_i, r_v_i, idx_r_i,
        input  predict_o
    );

    modport slave (
        input  w_v_i, idx_w_i, correct_i, r_v_i, idx_r_i,
        output predict_o
    );
endinterface

// File: rtl/bp_fe_bp_gshare_bht_sat_cnt_next.sv
// Next-value logic for one saturating direction counter: strengthen on correct,
// weaken toward the other direction on incorrect, never wrapping.
module bp_fe_bp_sat_cnt_next #(
    parameter int bp_cnt_sat_bits_p = 2
) (
    input  logic [bp_cnt_sat_bits_p-1:0] cnt,
    input  logic                         correct,
    output logic [bp_cnt_sat_bits_p-1:0] cnt_n
);
    localparam logic [bp_cnt_sat_bits_p-1:0] one_lp = bp_cnt_sat_bits_p'(1);

    logic msb;
    logic at_max;
    logic at_min;
    logic step_up;

    assign msb    = cnt[bp_cnt_sat_bits_p-1];
    assign at_max = &cnt;
    assign at_min = ~|cnt;
    // Taken side moves up when correct; not-taken side moves up only when wrong.
    assign step_up = correct ? msb : ~msb;

    always_comb begin
        cnt_n = cnt;
        if (step_up) begin
            if (!at_max) cnt_n = cnt + one_lp;
        end else begin
            if (!at_min) cnt_n = cnt - one_lp;
        end
    end
endmodule

// File: rtl/bp_fe_bp_gshare_bht.sv
// Gshare branch history table: array of saturating counters with a registered prediction.
// Define BP_GSHARE_WR_BYPASS_EN to forward a same-cycle update into the read path.
module bp_fe_bp_gshare_bht
    import bp_fe_bp_gshare_pkg::*;
#(
    parameter int bht_idx_width_p   = 9,
    parameter int bp_cnt_sat_bits_p = 2
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    bp_fe_bp_gshare_bht_if.slave   bht_if
);
    localparam int depth_lp = 1 << bht_idx_width_p;
    localparam logic [bp_cnt_sat_bits_p-1:0] cnt_init_lp =
        bp_cnt_sat_bits_p'(cnt_init(bp_cnt_sat_bits_p));

    logic [bp_cnt_sat_bits_p-1:0] cnt_q [depth_lp];
    logic [bp_cnt_sat_bits_p-1:0] cnt_d [depth_lp];
    logic [bp_cnt_sat_bits_p-1:0] cnt_w_cur;
    logic [bp_cnt_sat_bits_p-1:0] cnt_w_n;
    logic                         predict_q;
    logic                         predict_d;
    logic                         predict_r;

    assign cnt_w_cur = cnt_q[bht_if.idx_w_i];

    bp_fe_bp_sat_cnt_next #(
        .bp_cnt_sat_bits_p (bp_cnt_sat_bits_p)
    ) u_sat_cnt_next (
        .cnt     (cnt_w_cur),
        .correct (bht_if.correct_i),
        .cnt_n   (cnt_w_n)
    );

    always_comb begin
        cnt_d = cnt_q;
        if (bht_if.w_v_i) cnt_d[bht_if.idx_w_i] = cnt_w_n;
    end

    always_comb begin
        predict_r = cnt_q[bht_if.idx_r_i][bp_cnt_sat_bits_p-1];
`ifdef BP_GSHARE_WR_BYPASS_EN
        if (bht_if.w_v_i && (bht_if.idx_w_i == bht_if.idx_r_i))
            predict_r = cnt_w_n[bp_cnt_sat_bits_p-1];
`endif
    end

    always_comb begin
        predict_d = predict_q;
        if (bht_if.r_v_i) predict_d = predict_r;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < depth_lp; i++) cnt_q[i] <= cnt_init_lp;
            predict_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            predict_q <= predict_d;
        end
    end

    assign bht_if.predict_o = predict_q;
endmodule

// File: tb/tb_bp_fe_bp_gshare_bht.sv
// Directed scoreboard bench for the gshare BHT; expectations follow the build's bypass setting.
module tb_bp_fe_bp_gshare_bht;
    localparam int idx_w_lp = 9;

    typedef struct {
        logic  exp;
        string name;
    } sb_t;

    logic clk_i = 1'b0;
    logic reset_i = 1'b1;
    logic chk_v = 1'b0;
    int   total = 0;
    int   bad = 0;
    sb_t  exp_q[$];

`ifdef BP_GSHARE_WR_BYPASS_EN
    localparam logic same_cycle_exp_lp = 1'b1;
`else
    localparam logic same_cycle_exp_lp = 1'b0;
`endif

    bp_fe_bp_gshare_bht_if #(.bht_idx_width_p(idx_w_lp)) bht_if ();

    bp_fe_bp_gshare_bht #(
        .bht_idx_width_p   (idx_w_lp),
        .bp_cnt_sat_bits_p (2)
    ) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bht_if  (bht_if.slave)
    );

    always #5 clk_i = ~clk_i;

    // One cycle of stimulus, applied on the falling edge; chk queues an expected predict_o.
    task automatic cyc(input logic rst, input logic w_v, input int idx_w, input logic correct,
                       input logic r_v, input int idx_r, input logic chk, input logic exp,
                       input string name);
        sb_t e;
        @(negedge clk_i);
        reset_i           = rst;
        bht_if.w_v_i      = w_v;
        bht_if.idx_w_i    = idx_w[idx_w_lp-1:0];
        bht_if.correct_i  = correct;
        bht_if.r_v_i      = r_v;
        bht_if.idx_r_i    = idx_r[idx_w_lp-1:0];
        chk_v             = chk;
        if (chk) begin
            e.exp  = exp;
            e.name = name;
            exp_q.push_back(e);
        end
    endtask

    task automatic wr(input int idx, input logic correct);
        cyc(1'b0, 1'b1, idx, correct, 1'b0, 0, 1'b0, 1'b0, "");
    endtask

    task automatic rd(input int idx, input logic exp, input string name);
        cyc(1'b0, 1'b0, 0, 1'b0, 1'b1, idx, 1'b1, exp, name);
    endtask

    task automatic hold(input logic exp, input string name);
        cyc(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b1, exp, name);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, "");
    endtask

    // Monitor: compares predict_o after every edge whose cycle was marked for checking.
    initial begin
        sb_t e;
        forever begin
            @(posedge clk_i);
            if (chk_v) begin
                #1;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_underflow: predict_o=%0b with no expected entry", bht_if.predict_o);
                end else begin
                    e = exp_q.pop_front();
                    if (bht_if.predict_o !== e.exp) begin
                        bad++;
                        $display("FAIL %s: predict_o=%0b expected=%0b", e.name, bht_if.predict_o, e.exp);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bht_if.w_v_i     = 1'b0;
        bht_if.idx_w_i   = '0;
        bht_if.correct_i = 1'b0;
        bht_if.r_v_i     = 1'b0;
        bht_if.idx_r_i   = '0;

        cyc(1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, "");
        cyc(1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, "");
        hold(1'b0, "reset_predict");
        rd(0, 1'b0, "reset_idx0");
        rd(9'h1FF, 1'b0, "reset_idx1ff");

        // idx 5: 01 -> 10 -> 11 -> 11, then weaken 10 -> 01
        wr(5, 1'b0);
        rd(5, 1'b1, "idx5_flip_taken");
        wr(5, 1'b1);
        rd(5, 1'b1, "idx5_strong");
        wr(5, 1'b1);
        rd(5, 1'b1, "idx5_sat_max");
        wr(5, 1'b0);
        rd(5, 1'b1, "idx5_weak_taken");
        wr(5, 1'b0);
        rd(5, 1'b0, "idx5_flip_not_taken");

        // idx 7: 01 -> 00 -> 00 -> 01 -> 10
        wr(7, 1'b1);
        wr(7, 1'b1);
        rd(7, 1'b0, "idx7_sat_min");
        wr(7, 1'b0);
        rd(7, 1'b0, "idx7_weak_nt");
        wr(7, 1'b0);
        rd(7, 1'b1, "idx7_no_wrap");

        // same-index read and write in one cycle
        cyc(1'b0, 1'b1, 3, 1'b0, 1'b1, 3, 1'b1, same_cycle_exp_lp, "idx3_same_cycle");
        rd(3, 1'b1, "idx3_after");

        // different indices in one cycle are independent
        cyc(1'b0, 1'b1, 10, 1'b0, 1'b1, 11, 1'b1, 1'b0, "idx11_indep");
        rd(10, 1'b1, "idx10_written");

        // train several entries, then reset alongside a write
        wr(20, 1'b0);
        wr(21, 1'b0);
        wr(22, 1'b0);
        rd(21, 1'b1, "idx21_trained");
        hold(1'b1, "hold_taken_a");
        hold(1'b1, "hold_taken_b");
        cyc(1'b1, 1'b1, 20, 1'b1, 1'b1, 20, 1'b0, 1'b0, "");
        hold(1'b0, "post_reset_predict");
        rd(20, 1'b0, "post_reset_idx20");
        rd(21, 1'b0, "post_reset_idx21");
        rd(22, 1'b0, "post_reset_idx22");
        rd(5, 1'b0, "post_reset_idx5");
        rd(3, 1'b0, "post_reset_idx3");
        hold(1'b0, "post_reset_hold");
        wr(20, 1'b0);
        rd(20, 1'b1, "post_reset_init_weak");
        hold(1'b1, "final_hold");

        idle();
        idle();
        idle();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: pending=%0d expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
